mips_div_unit: RTL and testbench

MIPS_DIV_UNIT -- requirements
Module: mips_div_unit

---
 rtl/mips_div_unit_if.sv | 26 ++
 rtl/mips_div_unit.sv | 129 ++++++++++++
 tb/tb_mips_div_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mips_div_unit_if.sv
// Operand/result bundle for the MIPS DIV/DIVU unit: the master issues requests, the divider is the slave.
`default_nettype none

interface mips_div_unit_if;
  logic        Start;
  logic        Signed;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic [31:0] Lo;
  logic [31:0] Hi;
  logic        DivZero;

  modport master (
    output Start, Signed, A, B,
    input  Busy, Done, Lo, Hi, DivZero
  );

  modport slave (
    input  Start, Signed, A, B,
    output Busy, Done, Lo, Hi, DivZero
  );
endinterface

`default_nettype wire

// File: rtl/mips_div_unit.sv
// MIPS DIV/DIVU unit: 32-cycle restoring divider on magnitudes with sign fix-up.
// Latency is 34 edges from an accepted Start to the one-cycle Done pulse.
`default_nettype none

module mips_div_unit (
  input  wire logic     clk,
  input  wire logic     reset_n,
  mips_div_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_busy;
  logic        w_done;

  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_sa;
  logic        r_sb;
  logic [31:0] r_q;
  logic [31:0] r_mb;
  logic [32:0] r_rem;
  logic [4:0]  r_cnt;
  logic [31:0] r_lo;
  logic [31:0] r_hi;
  logic        r_dz;

  logic [33:0] w_sh;
  logic        w_ge;
  logic [32:0] w_sub;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b1;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.Start) w_next = S_PREP;
      end
      S_PREP: w_next = S_ITER;
      S_ITER: if (r_cnt == 5'd31) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Shifted remainder keeps its carry bit so the trial subtract never aliases.
  assign w_sh  = {r_rem, r_q[31]};
  assign w_ge  = (w_sh >= {2'b00, r_mb});
  assign w_sub = w_sh[32:0] - {1'b0, r_mb};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_q   <= '0;
      r_mb  <= '0;
      r_rem <= '0;
      r_cnt <= '0;
      r_lo  <= '0;
      r_hi  <= '0;
      r_dz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.Start) begin
            r_a   <= bus.A;
            r_b   <= bus.B;
            r_sa  <= bus.Signed & bus.A[31];
            r_sb  <= bus.Signed & bus.B[31];
            r_cnt <= '0;
          end
        end
        S_PREP: begin
          // 0x80000000 negates to itself, which is the correct unsigned magnitude.
          r_q   <= (r_a ^ {32{r_sa}}) + {31'd0, r_sa};
          r_mb  <= (r_b ^ {32{r_sb}}) + {31'd0, r_sb};
          r_rem <= '0;
        end
        S_ITER: begin
          r_rem <= w_ge ? w_sub : w_sh[32:0];
          r_q   <= {r_q[30:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
        end
        S_FIX: begin
          if (r_b == 32'd0) begin
            r_lo <= 32'hFFFF_FFFF;
            r_hi <= r_a;
            r_dz <= 1'b1;
          end else begin
            r_lo <= (r_sa ^ r_sb) ? (32'd0 - r_q) : r_q;
            r_hi <= r_sa ? (32'd0 - r_rem[31:0]) : r_rem[31:0];
            r_dz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy    = w_busy;
  assign bus.Done    = w_done;
  assign bus.Lo      = r_lo;
  assign bus.Hi      = r_hi;
  assign bus.DivZero = r_dz;

endmodule

`default_nettype wire

// File: tb/tb_mips_div_unit.sv
// Self-checking bench for mips_div_unit: directed corner cases plus randomized DIV/DIVU traffic.
`default_nettype none

module tb_mips_div_unit;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mips_div_unit_if bus ();

  mips_div_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks  = 0;
  int n_err     = 0;
  int dut_dones = 0;
  int exp_dones = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {DivZero, Hi, Lo} from ordinary 64-bit integer division.
  function automatic logic [64:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint na, nb, q, r;
    logic [63:0] qq, rr;
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    if (s) begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end else begin
      na = longint'({32'd0, a});
      nb = longint'({32'd0, b});
    end
    q  = na / nb;
    r  = na % nb;
    qq = q;
    rr = r;
    return {1'b0, rr[31:0], qq[31:0]};
  endfunction

  task automatic pin(input string name, input logic [64:0] got,
                     input logic [31:0] lo, input logic [31:0] hi, input logic dz);
    check({name, "_lo"}, got[31:0], lo);
    check({name, "_hi"}, got[63:32], hi);
    check({name, "_dz"}, 32'(got[64]), 32'(dz));
  endtask

  // Behavioural model: an accepted Start keeps the unit busy 35 cycles, results appear in the last.
  int          m_left = 0;
  logic [31:0] m_lo   = '0;
  logic [31:0] m_hi   = '0;
  logic        m_dz   = 1'b0;
  logic [64:0] m_pend = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_left = 0;
      m_lo   = '0;
      m_hi   = '0;
      m_dz   = 1'b0;
    end else if (m_left == 0) begin
      if (bus.Start) begin
        m_left = 35;
        m_pend = ref_div(bus.Signed, bus.A, bus.B);
      end
    end else begin
      m_left--;
      if (m_left == 1) {m_dz, m_hi, m_lo} = m_pend;
    end
  end

  always @(negedge clk) begin
    check("busy",    32'(bus.Busy),    32'(m_left != 0));
    check("done",    32'(bus.Done),    32'(m_left == 1));
    check("lo",      bus.Lo,           m_lo);
    check("hi",      bus.Hi,           m_hi);
    check("divzero", 32'(bus.DivZero), 32'(m_dz));
    if (bus.Done) dut_dones++;
  end

  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] elo, input logic [31:0] ehi, input logic edz,
                        input int mid_start, input bit done_start);
    int lat, bc;
    @(negedge clk);
    bus.Start = 1'b1; bus.Signed = s; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.Start = 1'b0;
    lat = 0;
    bc  = int'(bus.Busy);
    while (!bus.Done && lat < 40) begin
      @(negedge clk);
      lat++;
      bc += int'(bus.Busy);
      if (lat == mid_start) begin
        bus.Start = 1'b1; bus.Signed = 1'($urandom); bus.A = $urandom; bus.B = $urandom;
      end else begin
        bus.Start = 1'b0;
      end
    end
    check("latency", lat, 34);
    check("busy_cycles", bc, 35);
    check("res_lo", bus.Lo, elo);
    check("res_hi", bus.Hi, ehi);
    check("res_dz", 32'(bus.DivZero), 32'(edz));
    exp_dones++;
    if (done_start) begin
      bus.Start = 1'b1; bus.A = $urandom; bus.B = $urandom;
    end
    @(negedge clk);
    bus.Start = 1'b0;
    check("busy_after", 32'(bus.Busy), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [64:0] r;
    logic        s;
    logic [31:0] a, b;

    bus.Start = 1'b0; bus.Signed = 1'b0; bus.A = '0; bus.B = '0;

    pin("m_u100_7",  ref_div(1'b0, 32'd100, 32'd7),              32'd14, 32'd2, 1'b0);
    pin("m_sn7_2",   ref_div(1'b1, 32'hFFFF_FFF9, 32'd2),        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    pin("m_s7_n2",   ref_div(1'b1, 32'd7, 32'hFFFF_FFFE),        32'hFFFF_FFFD, 32'd1, 1'b0);
    pin("m_dz",      ref_div(1'b1, 32'h1234_5678, 32'd0),        32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    pin("m_ovf_s",   ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000, 32'd0, 1'b0);
    pin("m_ovf_u",   ref_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0, 32'h8000_0000, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("rst_lo", bus.Lo, 32'd0);
    check("rst_hi", bus.Hi, 32'd0);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    reset_n = 1'b1;

    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0, 1'b0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 0, 1'b0);
    run_op(1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 0, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 0, 1'b0);
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 0, 1'b0);
    run_op(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 15, 1'b1);

    // Abandon an operation partway through the iterations.
    @(negedge clk);
    bus.Start = 1'b1; bus.Signed = 1'b0; bus.A = 32'd1000; bus.B = 32'd7;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (12) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.Busy), 32'd0);
    check("mid_rst_done", 32'(bus.Done), 32'd0);
    check("mid_rst_lo", bus.Lo, 32'd0);
    check("mid_rst_hi", bus.Hi, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    run_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      a = pick();
      b = pick();
      r = ref_div(s, a, b);
      run_op(s, a, b, r[31:0], r[63:32], r[64],
             (i % 5 == 0) ? int'($urandom_range(3, 30)) : 0, (i % 7 == 0));
    end

    check("done_count", dut_dones, exp_dones);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
